// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares the 16-bit VRAM port between display fetch (absolute priority)
// and 32-bit CPU accesses split into two halfword cycles.
module vga_vram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int WAIT_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic              disp_valid_o,
  output logic [15:0]       disp_rdata_o,
  input  logic              cpu_valid_i,
  input  logic [ADDR_W:0]   cpu_addr_i,
  input  logic [3:0]        cpu_wstrb_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic              cpu_ready_o,
  output logic [31:0]       cpu_rdata_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [1:0]        ram_be_o,
  output logic [15:0]       ram_wdata_o,
  input  logic [15:0]       ram_rdata_i,
  output logic [WAIT_W-1:0] cpu_wait_max_o
);
  typedef enum logic [2:0] {IDLE, LO, HI, WAITRD, DONE} state_t;
  typedef enum logic [1:0] {T_NONE, T_DISP, T_LO, T_HI} tag_t;
  state_t state_q, state_d;
  tag_t tag_q, tag_d;
  logic [ADDR_W-2:0] idx_q;
  logic [3:0] wstrb_q;
  logic [31:0] wdata_q;
  logic [15:0] lo_q, hi_q;
  logic [WAIT_W-1:0] stall_q, stall_d, wmax_q;
  logic hi_half, rd;
  logic [1:0] half_be;
  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, cpu_addr_i[1:0]};
  assign hi_half = state_q == HI;
  assign rd = wstrb_q == 4'h0;
  assign half_be = hi_half ? wstrb_q[3:2] : wstrb_q[1:0];
  assign disp_valid_o = tag_q == T_DISP;
  assign disp_rdata_o = disp_valid_o ? ram_rdata_i : 16'h0;
  assign cpu_ready_o = state_q == DONE && !reset_i;
  assign cpu_rdata_o = {hi_q, lo_q};
  assign cpu_wait_max_o = wmax_q;
  always_comb begin
    state_d = state_q;
    tag_d = T_NONE;
    stall_d = stall_q;
    ram_addr_o = '0;
    ram_we_o = 1'b0;
    ram_be_o = 2'b00;
    ram_wdata_o = 16'h0;
    case (state_q)
      IDLE: if (cpu_valid_i) begin
        state_d = LO;
        stall_d = '0;
      end
      LO, HI:
        if (!cpu_valid_i) state_d = IDLE;
        else if (disp_req_i) stall_d = &stall_q ? stall_q : stall_q + 1'b1;
        else begin
          // a write half with no strobes consumes its slot without touching the RAM
          if (rd || half_be != 2'b00) begin
            ram_addr_o = {idx_q, hi_half};
            ram_we_o = !rd;
            ram_be_o = rd ? 2'b11 : half_be;
            ram_wdata_o = hi_half ? wdata_q[31:16] : wdata_q[15:0];
            tag_d = !rd ? T_NONE : hi_half ? T_HI : T_LO;
          end
          state_d = !hi_half ? HI : rd ? WAITRD : DONE;
        end
      WAITRD: state_d = cpu_valid_i ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
    if (disp_req_i) begin
      ram_addr_o = disp_addr_i;
      ram_we_o = 1'b0;
      ram_be_o = 2'b11;
      ram_wdata_o = 16'h0;
      tag_d = T_DISP;
    end
    if (reset_i) begin
      state_d = IDLE;
      tag_d = T_NONE;
      ram_addr_o = '0;
      ram_we_o = 1'b0;
      ram_be_o = 2'b00;
      ram_wdata_o = 16'h0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      tag_q <= T_NONE;
      idx_q <= '0;
      wstrb_q <= 4'h0;
      wdata_q <= 32'h0;
      lo_q <= 16'h0;
      hi_q <= 16'h0;
      stall_q <= '0;
      wmax_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q <= tag_d;
      stall_q <= stall_d;
      if (state_q == IDLE && cpu_valid_i) begin
        idx_q <= cpu_addr_i[ADDR_W:2];
        wstrb_q <= cpu_wstrb_i;
        wdata_q <= cpu_wdata_i;
      end
      if (tag_q == T_LO) lo_q <= ram_rdata_i;
      if (tag_q == T_HI) hi_q <= ram_rdata_i;
      if (state_q == DONE && stall_q > wmax_q) wmax_q <= stall_q;
    end
  end
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb_vga_vram_arbiter: directed stimulus with a queue scoreboard for display and CPU read data.
module tb_vga_vram_arbiter;
  localparam int AW = 12;
  localparam int WW = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, disp_req, disp_valid, cpu_valid, cpu_ready, ram_we, ld;
  logic [AW-1:0] disp_addr, ram_addr;
  logic [15:0] disp_rdata, ram_wdata, ram_rdata;
  logic [AW:0] cpu_addr;
  logic [3:0] cpu_wstrb;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic [1:0] ram_be;
  logic [WW-1:0] cpu_wait_max;
  logic [15:0] mem [0:4095];
  logic [15:0] dq[$];
  logic [32:0] cq[$];
  int vecs = 0, errs = 0;
  int nrd = 0, nwr = 0;
  logic [AW-1:0] last_a;
  logic [1:0] last_be;
  logic [15:0] last_d;

  vga_vram_arbiter #(.ADDR_W(AW), .WAIT_W(WW)) dut (
    .clk_i(clk), .reset_i(reset),
    .disp_req_i(disp_req), .disp_addr_i(disp_addr),
    .disp_valid_o(disp_valid), .disp_rdata_o(disp_rdata),
    .cpu_valid_i(cpu_valid), .cpu_addr_i(cpu_addr), .cpu_wstrb_i(cpu_wstrb),
    .cpu_wdata_i(cpu_wdata), .cpu_ready_o(cpu_ready), .cpu_rdata_o(cpu_rdata),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .cpu_wait_max_o(cpu_wait_max)
  );

  function automatic logic [15:0] init_val(input logic [11:0] a);
    case (a)
      12'h010: return 16'h1234;
      12'h011: return 16'hABCD;
      12'h014: return 16'h1111;
      12'h015: return 16'h2222;
      12'h018: return 16'h7777;
      12'h019: return 16'h8888;
      default: return {4'h0, a} ^ 16'h5A5A;
    endcase
  endfunction

  // registered-read single-port RAM
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_val(i[11:0]);
    end else begin
      ram_rdata <= mem[ram_addr];
      if (ram_we && ram_be[0]) mem[ram_addr][7:0] <= ram_wdata[7:0];
      if (ram_we && ram_be[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
    end
  end

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic monitor();
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (disp_valid) begin
        if (dq.size() == 0) check("disp_unexpected_valid", {31'h0, disp_valid}, 32'h0);
        else check("disp_rdata", {16'h0, disp_rdata}, {16'h0, dq.pop_front()});
      end
      if (cpu_ready) begin
        if (cq.size() == 0) check("cpu_unexpected_ready", {31'h0, cpu_ready}, 32'h0);
        else begin
          e = cq.pop_front();
          if (e[32]) check("cpu_rdata", cpu_rdata, e[31:0]);
        end
      end
      if (ram_we) begin
        nwr++;
        last_a = ram_addr;
        last_be = ram_be;
        last_d = ram_wdata;
      end
      if (!ram_we && ram_be != 2'b00 && !disp_req) nrd++;
    end
  endtask

  // caller is at posedge+1 of the cycle in which cpu_valid first rises
  task automatic cpu_go(input logic [12:0] a, input logic [3:0] s, input logic [31:0] d, output int lat);
    cpu_valid = 1'b1;
    cpu_addr = a;
    cpu_wstrb = s;
    cpu_wdata = d;
    lat = 0;
    @(negedge clk);
    while (!cpu_ready && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end
    if (!cpu_ready) check("cpu_timeout", {31'h0, cpu_ready}, 32'h1);
    @(posedge clk); #1;
    cpu_valid = 1'b0;
  endtask

  task automatic disp_burst(input int n, input logic [11:0] base);
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      disp_req = 1'b1;
      disp_addr = base + k[11:0];
      dq.push_back(init_val(disp_addr));
      @(posedge clk); #1;
    end
    disp_req = 1'b0;
  endtask

  task automatic run();
    int lat, r0, w0;
    reset = 1'b1; ld = 1'b1; disp_req = 1'b0; disp_addr = '0;
    cpu_valid = 1'b0; cpu_addr = '0; cpu_wstrb = 4'h0; cpu_wdata = 32'h0;
    @(posedge clk); #1;
    ld = 1'b0;
    @(negedge clk);
    check("rst_outputs", {26'h0, disp_valid, cpu_ready, ram_we, ram_be, |ram_addr},32'h0);
    check("rst_data", {disp_rdata, ram_wdata}, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_wait_max", {24'h0, cpu_wait_max}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    // plain read
    r0 = nrd; w0 = nwr;
    cq.push_back({1'b1, 32'hABCD1234});
    cpu_go(13'h020, 4'h0, 32'h0, lat);
    check("read_latency", lat, 4);
    check("read_ram_reads", nrd - r0, 2);
    check("read_ram_writes", nwr - w0, 0);
    // full write
    @(posedge clk); #1;
    r0 = nrd; w0 = nwr;
    cq.push_back({1'b0, 32'h0});
    cpu_go(13'h024, 4'hF, 32'hDEADBEEF, lat);
    check("write_latency", lat, 3);
    check("write_ram_writes", nwr - w0, 2);
    check("write_last_be", {30'h0, last_be}, 32'h3);
    check("write_mem_lo", {16'h0, mem[12'h012]}, 32'h0000BEEF);
    check("write_mem_hi", {16'h0, mem[12'h013]}, 32'h0000DEAD);
    // partial write: only byte 2
    @(posedge clk); #1;
    w0 = nwr;
    cq.push_back({1'b0, 32'h0});
    cpu_go(13'h028, 4'b0100, 32'hDEADBEEF, lat);
    check("pwrite_latency", lat, 3);
    check("pwrite_ram_writes", nwr - w0, 1);
    check("pwrite_addr_be", {18'h0, last_a, last_be}, {18'h0, 12'h015, 2'b01});
    check("pwrite_byte", {24'h0, last_d[7:0]}, 32'hAD);
    check("pwrite_mem", {mem[12'h014], mem[12'h015]}, 32'h111122AD);
    // collision: 5 display cycles while the CPU sits in LO
    @(posedge clk); #1;
    r0 = nrd;
    cq.push_back({1'b1, 32'hABCD1234});
    fork
      cpu_go(13'h020, 4'h0, 32'h0, lat);
      disp_burst(5, 12'h100);
    join
    check("coll_latency", lat, 9);
    check("coll_ram_reads", nrd - r0, 2);
    check("coll_wait_max", {24'h0, cpu_wait_max}, 32'd5);
    // saturation of the stall statistic
    @(posedge clk); #1;
    cq.push_back({1'b1, 32'hDEADBEEF});
    fork
      cpu_go(13'h024, 4'h0, 32'h0, lat);
      disp_burst(300, 12'h200);
    join
    check("sat_latency", lat, 304);
    check("sat_wait_max", {24'h0, cpu_wait_max}, 32'd255);
    // abort: cpu_valid drops in LO
    @(posedge clk); #1;
    r0 = nrd; w0 = nwr;
    cpu_valid = 1'b1; cpu_addr = 13'h020; cpu_wstrb = 4'h0;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    @(negedge clk);
    check("abort_no_issue", {29'h0, ram_we, ram_be}, 32'h0);
    @(posedge clk); #1;
    cq.push_back({1'b1, 32'hDEADBEEF});
    cpu_go(13'h024, 4'h0, 32'h0, lat);
    check("abort_next_latency", lat, 4);
    check("abort_ram_reads", nrd - r0, 2);
    // reset during HI of a write
    @(posedge clk); #1;
    cpu_valid = 1'b1; cpu_addr = 13'h030; cpu_wstrb = 4'hF; cpu_wdata = 32'h55667788;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_hi_we", {31'h0, ram_we}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    cpu_valid = 1'b0;
    @(negedge clk);
    check("rst_hi_mem", {mem[12'h018], mem[12'h019]}, 32'h77888888);
    check("rst_wait_cleared", {24'h0, cpu_wait_max}, 32'h0);
    @(posedge clk); #1;
    cq.push_back({1'b1, 32'hABCD1234});
    cpu_go(13'h020, 4'h0, 32'h0, lat);
    check("rst_next_latency", lat, 4);
    // reset clears a pending display tag
    @(posedge clk); #1;
    disp_req = 1'b1; disp_addr = 12'h100;
    dq.push_back(init_val(12'h100));
    @(posedge clk); #1;
    reset = 1'b1; disp_addr = 12'h101;
    @(posedge clk); #1;
    reset = 1'b0; disp_req = 1'b0;
    @(negedge clk);
    check("rst_tag_clear", {31'h0, disp_valid}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("disp_queue_empty", dq.size(), 0);
    check("cpu_queue_empty", cq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  endtask

  initial begin
    fork
      monitor();
      run();
    join_any
  end
endmodule
